// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter and initialisation sequencer for a
// single-write-port register file. After reset (or a clr pulse) every
// address is swept with INIT_VAL before any requester is granted.
module regfile_wr_arbiter #(
  parameter int N       = 4,
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 4,
  parameter logic [D_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic [N-1:0]           req,
  input  logic [N*A_WIDTH-1:0]   req_addr,
  input  logic [N*D_WIDTH-1:0]   req_data,
  output logic [N-1:0]           gnt,
  output logic                   wren,
  output logic [A_WIDTH-1:0]     waddr,
  output logic [D_WIDTH-1:0]     wdata,
  output logic                   init_done
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {INIT, ARB} state_t;

  state_t             state;
  logic [A_WIDTH-1:0] cnt;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      gidx;
  logic               gvalid;
  logic [PW-1:0]      ptr_nxt;

  logic [A_WIDTH-1:0] addr_a [N];
  logic [D_WIDTH-1:0] data_a [N];

  // unpack the flattened per-requester address/data buses
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*A_WIDTH +: A_WIDTH];
    assign data_a[i] = req_data[i*D_WIDTH +: D_WIDTH];
  end

  // first asserted req searching ptr, ptr+1, ... with wrap; blocked in INIT and on clr
  always_comb begin
    gvalid = 1'b0;
    gidx   = '0;
    if (state == ARB && !clr) begin
      for (int k = 0; k < N; k++) begin
        if (!gvalid && req[(int'(ptr) + k) % N]) begin
          gvalid = 1'b1;
          gidx   = PW'((int'(ptr) + k) % N);
        end
      end
    end
  end

  // one-hot grant decode
  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++)
      gnt[i] = gvalid && (gidx == PW'(i));
  end

  // pointer moves just past the granted requester
  assign ptr_nxt = (gidx == PW'(N-1)) ? '0 : gidx + PW'(1);

  // sweep / arbitration sequencer with registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      ptr       <= '0;
      wren      <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (clr) begin
            // restart the sweep; this edge writes nothing
            cnt  <= '0;
            wren <= 1'b0;
          end else begin
            wren  <= 1'b1;
            waddr <= cnt;
            wdata <= INIT_VAL;
            if (cnt == {A_WIDTH{1'b1}}) begin
              cnt       <= '0;
              state     <= ARB;
              init_done <= 1'b1;
            end else begin
              cnt <= cnt + A_WIDTH'(1);
            end
          end
        end
        ARB: begin
          if (clr) begin
            // ptr is kept so fairness carries across a re-init
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
            wren      <= 1'b0;
          end else if (gvalid) begin
            wren  <= 1'b1;
            waddr <= addr_a[gidx];
            wdata <= data_a[gidx];
            ptr   <= ptr_nxt;
          end else begin
            wren <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (N=4, D_WIDTH=8, A_WIDTH=4, INIT_VAL=0).
module tb_regfile_wr_arbiter;

  localparam int N = 4, DW = 8, AW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      gnt;
  logic              wren;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic              init_done;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem [2**AW];

  regfile_wr_arbiter #(.N(N), .D_WIDTH(DW), .A_WIDTH(AW), .INIT_VAL('0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt), .wren(wren), .waddr(waddr), .wdata(wdata),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  // register file model written from the arbiter's write port
  always @(posedge clk) if (wren) mem[waddr] <= wdata;

  // expects the sweep to begin at the next rising edge; leaves time at edge+1
  task automatic test_sweep(input string name);
    for (int c = 0; c < 2**AW; c++) begin
      @(posedge clk); #1;
      tests++;
      if (wren !== 1'b1 || waddr !== AW'(c) || wdata !== 8'h00) begin
        fails++;
        $display("FAIL %s c=%0d: wren=%b waddr=%0d wdata=%h, need 1/%0d/00", name, c, wren, waddr, wdata, c);
      end
      tests++;
      if (init_done !== (c == 2**AW-1)) begin
        fails++;
        $display("FAIL %s init_done c=%0d: got %b need %b", name, c, init_done, (c == 2**AW-1));
      end
      if (c != 2**AW-1) begin
        tests++;
        if (gnt !== 4'b0000) begin
          fails++;
          $display("FAIL %s gnt during sweep c=%0d: got %b need 0000", name, c, gnt);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clr = 1'b0; req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = AW'(i);
      req_data[i*DW +: DW] = DW'(8'hA0 + i);
    end
    #1;
    tests++;
    if (wren !== 1'b0 || waddr !== '0 || wdata !== '0 || init_done !== 1'b0 || gnt !== '0) begin
      fails++;
      $display("FAIL reset_state: wren=%b waddr=%0d wdata=%h init_done=%b gnt=%b, need all 0",
               wren, waddr, wdata, init_done, gnt);
    end
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    test_sweep("init_sweep");
  endtask

  task automatic test_round_robin;
    req = 4'b1111;
    #1;
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (gnt !== 4'(1 << (k % 4))) begin
        fails++;
        $display("FAIL rr_gnt k=%0d: got %b need %b", k, gnt, 4'(1 << (k % 4)));
      end
      @(posedge clk); #1;
      tests++;
      if (wren !== 1'b1 || waddr !== AW'(k % 4) || wdata !== DW'(8'hA0 + k % 4)) begin
        fails++;
        $display("FAIL rr_write k=%0d: wren=%b waddr=%0d wdata=%h need 1/%0d/%h",
                 k, wren, waddr, wdata, k % 4, 8'hA0 + k % 4);
      end
    end
    req = '0; #1;
    tests++;
    if (gnt !== 4'b0000) begin
      fails++; $display("FAIL rr_idle_gnt: got %b need 0000", gnt);
    end
    @(posedge clk); #1;
    tests++;
    if (wren !== 1'b0 || waddr !== 4'd3 || wdata !== 8'hA3) begin
      fails++;
      $display("FAIL rr_idle_hold: wren=%b waddr=%0d wdata=%h need 0/3/a3", wren, waddr, wdata);
    end
  endtask

  // ptr is 0 on entry
  task automatic test_fairness;
    req = 4'b0100; #1;
    tests++;
    if (gnt !== 4'b0100) begin fails++; $display("FAIL fair_p2: got %b need 0100", gnt); end
    @(posedge clk); #1;
    req = 4'b0101; #1;
    tests++;
    if (gnt !== 4'b0001) begin fails++; $display("FAIL fair_wrap: got %b need 0001", gnt); end
    @(posedge clk); #1;
    tests++;
    if (gnt !== 4'b0100) begin fails++; $display("FAIL fair_next: got %b need 0100", gnt); end
    @(posedge clk); #1;
    // ptr now 3: grant port 3 alone to bring ptr back to 0
    req = 4'b1000; #1;
    tests++;
    if (gnt !== 4'b1000) begin fails++; $display("FAIL fair_p3: got %b need 1000", gnt); end
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic test_same_addr;
    req_addr[1*AW +: AW] = 4'd5; req_data[1*DW +: DW] = 8'h11;
    req_addr[3*AW +: AW] = 4'd5; req_data[3*DW +: DW] = 8'h33;
    req = 4'b1010; #1;
    tests++;
    if (gnt !== 4'b0010) begin fails++; $display("FAIL conflict_g1: got %b need 0010", gnt); end
    @(posedge clk); #1;
    req = 4'b1000;
    tests++;
    if (wren !== 1'b1 || waddr !== 4'd5 || wdata !== 8'h11) begin
      fails++; $display("FAIL conflict_w1: wren=%b waddr=%0d wdata=%h need 1/5/11", wren, waddr, wdata);
    end
    tests++;
    if (gnt !== 4'b1000) begin fails++; $display("FAIL conflict_g3: got %b need 1000", gnt); end
    @(posedge clk); #1;
    req = '0;
    tests++;
    if (wren !== 1'b1 || waddr !== 4'd5 || wdata !== 8'h33) begin
      fails++; $display("FAIL conflict_w3: wren=%b waddr=%0d wdata=%h need 1/5/33", wren, waddr, wdata);
    end
    @(posedge clk); #1;
    tests++;
    if (mem[5] !== 8'h33) begin fails++; $display("FAIL conflict_read: got %h need 33", mem[5]); end
  endtask

  task automatic test_clr;
    req_addr[1*AW +: AW] = 4'd9; req_data[1*DW +: DW] = 8'h5A;
    req = 4'b0010; clr = 1'b1; #1;
    tests++;
    if (gnt !== 4'b0000) begin fails++; $display("FAIL clr_gnt: got %b need 0000", gnt); end
    @(posedge clk); #1;
    clr = 1'b0;
    tests++;
    if (wren !== 1'b0 || init_done !== 1'b0 || gnt !== 4'b0000) begin
      fails++; $display("FAIL clr_after: wren=%b init_done=%b gnt=%b need 0/0/0000", wren, init_done, gnt);
    end
    test_sweep("clr_sweep");
    tests++;
    if (gnt !== 4'b0010) begin fails++; $display("FAIL clr_first_arb: got %b need 0010", gnt); end
    @(posedge clk); #1;
    req = '0;
    tests++;
    if (wren !== 1'b1 || waddr !== 4'd9 || wdata !== 8'h5A) begin
      fails++; $display("FAIL clr_write: wren=%b waddr=%0d wdata=%h need 1/9/5a", wren, waddr, wdata);
    end
  endtask

  task automatic test_reset_mid_sweep;
    bit seen = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int c = 0; c < 24 && !seen; c++) begin
      @(posedge clk); #1;
      if (wren && waddr == 4'd7) seen = 1'b1;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL midsweep_wait: waddr 7 not reached, waddr=%0d", waddr); end
    #2 rst_n = 1'b0; #1;
    tests++;
    if (wren !== 1'b0 || waddr !== '0 || wdata !== '0 || init_done !== 1'b0 || gnt !== '0) begin
      fails++;
      $display("FAIL midsweep_async: wren=%b waddr=%0d wdata=%h init_done=%b gnt=%b need all 0",
               wren, waddr, wdata, init_done, gnt);
    end
    @(negedge clk); rst_n = 1'b1;
    test_sweep("restart_sweep");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fairness();
    test_same_addr();
    test_clr();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Round-robin write-port arbiter and initialisation sequencer for the single-write-port register file (D_WIDTH data, A_WIDTH address).
- Shares the one write port among N requesters using a req/gnt handshake and drives registered wren/waddr/wdata into the register file.
- The register file has no reset. After reset, and on request, this block first sweeps every address and writes INIT_VAL before it grants any requester.

Parameters:
- N, 4, number of write requesters (N >= 1)
- D_WIDTH, 8, data width; matches the register file
- A_WIDTH, 4, address width; depth is 2**A_WIDTH
- INIT_VAL, 0, value written to every entry during initialisation (D_WIDTH bits)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  single-cycle pulse; restarts the initialisation sweep
- req  input  N  per-requester write request; the requester holds req, addr and data stable until it sees gnt
- req_addr  input  N*A_WIDTH  flattened addresses; requester i uses bits [i*A_WIDTH +: A_WIDTH]
- req_data  input  N*D_WIDTH  flattened data; requester i uses bits [i*D_WIDTH +: D_WIDTH]
- gnt  output  N  one-hot (or zero) combinational grant; the request is accepted in the cycle gnt[i]=1
- wren  output  1  registered write enable to the register file
- waddr  output  A_WIDTH  registered write address
- wdata  output  D_WIDTH  registered write data
- init_done  output  1  registered; high once the sweep completes and arbitration is enabled

Behaviour:
- Reset (rst_n=0, asynchronous), all state forced as follows:
  - state=INIT, sweep counter cnt=0, round-robin pointer ptr=0
  - wren=0, waddr=0, wdata=0, init_done=0
  - gnt=0 combinationally
- States:
  - INIT: sweep. Each clock edge loads wren<=1, waddr<=cnt, wdata<=INIT_VAL and increments cnt.
  - On the edge where cnt==2**A_WIDTH-1: load the last write, set cnt<=0, state<=ARB, init_done<=1.
  - The sweep therefore takes exactly 2**A_WIDTH cycles. gnt is held at 0 throughout INIT.
- ARB state, per cycle:
  - gnt selects the first asserted req searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - At most one gnt bit is high; gnt is all zero if no req is asserted.
- ARB state, on the clock edge:
  - If granting i: wren<=1, waddr<=req_addr[i], wdata<=req_data[i], ptr<=(i+1) mod N.
  - If no grant: wren<=0; waddr, wdata and ptr hold.
- Latency: a grant in cycle t presents the write on wren/waddr/wdata in cycle t+1, so the register file is written at the edge ending cycle t+1. Back-to-back grants give one write per cycle with no bubbles.
- Fairness:
  - A requester holding req is granted within N cycles.
  - With N=1, the single requester is granted every cycle it asserts req.
- Same-address requests from different ports are serialised in grant order; the last granted write wins. No merging or combining is performed.
- clr in ARB:
  - gnt is forced to 0 in that cycle combinationally, so no request is accepted.
  - On the edge: state<=INIT, cnt<=0, init_done<=0, wren<=0.
  - A write already registered from the previous cycle is still presented that cycle (the edge only clears wren for the following cycle).
  - ptr holds.
- clr in INIT restarts the sweep: cnt<=0, and the current-edge write is suppressed (wren<=0).
- Reset during a sweep or mid-arbitration aborts immediately. Pending requests are not accepted; requesters keep req asserted and are granted after the new sweep.
- wdata/waddr are don't-care when wren=0, but must hold their last value (no X).

Test Plan:
- Reset release, N=4, A_WIDTH=4, INIT_VAL=0, no req:
  - wren=1 for exactly 16 cycles with waddr 0..15 and wdata=0.
  - init_done rises on the edge loading waddr=15; gnt stays 0 throughout.
- After init, req=4'b1111 held with addr i and data 8'hA0+i:
  - Grants in order 0,1,2,3,0,… with no gaps.
  - Writes appear one cycle after each grant: (0,A0),(1,A1),(2,A2),(3,A3).
- Fairness:
  - Grant port 2, then assert req=4'b0101 → gnt=4'b0001 (ptr=3 wraps to 0).
  - Next cycle gnt=4'b0100.
- Same-address conflict: ports 1 and 3 both target addr 5 with data 8'h11 and 8'h33, ptr=0 → two writes (5,11) then (5,33); a regfile read of 5 returns 8'h33.
- clr pulse while req=4'b0010 is held:
  - gnt=0 in the clr cycle.
  - A 16-cycle sweep follows, then port 1 is granted in the first ARB cycle.
- rst_n asserted at sweep address 7:
  - Outputs go to reset values asynchronously.
  - After release the sweep restarts at waddr=0 and runs the full 16 cycles.
